// File: rtl/pe_op_sequencer.sv
// pe_op_sequencer: walks operand memories A/B and opcode memory C one element
// at a time, executes the opcode on the fetched operands and streams one result
// per element over a valid/ready interface. One pass per accepted start.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, cfg_len         pass request and element count (0..2^ADDR_W)
//   mem_addr, opc_addr     read addresses to memA/memB and memC
//   memA_in/memB_in/memC_in read data, valid the cycle after the address
//   res_valid/res_ready    result stream handshake
//   res_data/res_idx/res_flags result payload, flags = {illegal, carry, zero}
//   busy, done             pass in progress / pass complete (level)
//   illegal_cnt            saturating count of illegal opcodes this pass
module pe_op_sequencer #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned OPC_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W:0]       cfg_len,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [OPC_ADDR_W-1:0] opc_addr,
  input  logic [DATA_W-1:0]     memA_in,
  input  logic [DATA_W-1:0]     memB_in,
  input  logic [7:0]            memC_in,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_W-1:0]     res_data,
  output logic [ADDR_W-1:0]     res_idx,
  output logic [2:0]            res_flags,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            illegal_cnt
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_OUTPUT,
    S_FINISH
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] idx;

  logic [DATA_W:0]   sum_c;
  logic [DATA_W-1:0] alu_res_c;
  logic              alu_carry_c;
  logic              alu_illegal_c;
  logic              last_c;

  // Opcode execution on the operands currently presented by the memories
  always_comb begin
    sum_c         = {1'b0, memA_in} + {1'b0, memB_in};
    alu_res_c     = memA_in;
    alu_carry_c   = 1'b0;
    alu_illegal_c = 1'b0;
    case (memC_in)
      8'd0: begin
        alu_res_c   = sum_c[DATA_W-1:0];
        alu_carry_c = sum_c[DATA_W];
      end
      8'd1: begin
        alu_res_c   = memA_in - memB_in;
        alu_carry_c = (memA_in < memB_in);
      end
      8'd2: alu_res_c = memA_in & memB_in;
      8'd3: alu_res_c = memA_in | memB_in;
      8'd4: alu_res_c = memA_in ^ memB_in;
      8'd5: alu_res_c = memA_in * memB_in;
      8'd6: alu_res_c = memA_in << memB_in[SH_W-1:0];
      8'd7: alu_res_c = memA_in >> memB_in[SH_W-1:0];
      8'd8: alu_res_c = (memA_in > memB_in) ? memA_in : memB_in;
      default: begin
        alu_res_c     = memA_in;
        alu_illegal_c = 1'b1;
      end
    endcase
  end

  // len_q is at least 1 whenever this is consulted, so the subtraction never wraps
  assign last_c = ({1'b0, idx} == (len_q - (ADDR_W+1)'(1)));

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      len_q       <= '0;
      idx         <= '0;
      mem_addr    <= '0;
      opc_addr    <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_idx     <= '0;
      res_flags   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q       <= cfg_len;
            idx         <= '0;
            illegal_cnt <= '0;
            done        <= 1'b0;
            busy        <= 1'b1;
            state       <= (cfg_len == '0) ? S_FINISH : S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_addr <= idx;
          opc_addr <= idx[OPC_ADDR_W-1:0];
          state    <= S_CAPTURE;
        end
        S_CAPTURE: begin
          res_data  <= alu_res_c;
          res_idx   <= idx;
          res_flags <= {alu_illegal_c, alu_carry_c, (alu_res_c == '0)};
          res_valid <= 1'b1;
          if (alu_illegal_c && (illegal_cnt != 8'hFF)) begin
            illegal_cnt <= illegal_cnt + 8'd1;
          end
          state <= S_OUTPUT;
        end
        S_OUTPUT: begin
          // Payload is held until the sink takes it
          if (res_ready) begin
            res_valid <= 1'b0;
            if (last_c) begin
              state <= S_FINISH;
            end else begin
              idx   <= idx + ADDR_W'(1);
              state <= S_ISSUE;
            end
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_op_sequencer.sv
module tb_pe_op_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] cfg_len;
  logic [10:0] mem_addr;
  logic [7:0]  opc_addr;
  logic [31:0] memA_in;
  logic [31:0] memB_in;
  logic [7:0]  memC_in;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [10:0] res_idx;
  logic [2:0]  res_flags;
  logic        busy;
  logic        done;
  logic [7:0]  illegal_cnt;

  logic [31:0] mem_a [2048];
  logic [31:0] mem_b [2048];
  logic [7:0]  mem_c [256];

  typedef struct packed {
    logic [31:0] data;
    logic [10:0] idx;
    logic [2:0]  flags;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  logic [10:0] last_idx;
  logic [8:0]  opc256;

  pe_op_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_len    (cfg_len),
    .mem_addr   (mem_addr),
    .opc_addr   (opc_addr),
    .memA_in    (memA_in),
    .memB_in    (memB_in),
    .memC_in    (memC_in),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_idx    (res_idx),
    .res_flags  (res_flags),
    .busy       (busy),
    .done       (done),
    .illegal_cnt(illegal_cnt)
  );

  // Memory read data follows the registered address
  assign memA_in = mem_a[mem_addr];
  assign memB_in = mem_b[mem_addr];
  assign memC_in = mem_c[opc_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timeout", name);
  endtask

  // Scoreboard monitor: every transfer is compared against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: got idx %0d data 0x%0h expected none", res_idx, res_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_data", 64'(res_data), 64'(e.data));
        check("res_idx", 64'(res_idx), 64'(e.idx));
        check("res_flags", 64'(res_flags), 64'(e.flags));
      end
      last_idx = res_idx;
    end
    if (rst_n && busy && mem_addr == 11'd256) opc256 = {1'b0, opc_addr};
  end

  task automatic push(input logic [31:0] d, input int i, input logic [2:0] f);
    exp_t e;
    e.data  = d;
    e.idx   = 11'(i);
    e.flags = f;
    exp_q.push_back(e);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    for (int i = 0; i < 256; i++) mem_c[i] = '0;
  endtask

  task automatic start_pass(input int len);
    @(posedge clk);
    #1 cfg_len = 12'(len);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int i;
    i = 0;
    while (!done && i < limit) begin
      @(negedge clk);
      i++;
    end
    if (!done) fail_now(name);
  endtask

  task automatic wait_valid_idx(input string name, input int idx, input int limit);
    int i;
    i = 0;
    @(negedge clk);
    while (!(res_valid && res_idx == 11'(idx)) && i < limit) begin
      @(negedge clk);
      i++;
    end
    if (!(res_valid && res_idx == 11'(idx))) fail_now(name);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_opc_addr"}, 64'(opc_addr), 64'd0);
    check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_res_data"}, 64'(res_data), 64'd0);
    check({tag, "_res_idx"}, 64'(res_idx), 64'd0);
    check({tag, "_res_flags"}, 64'(res_flags), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_illegal_cnt"}, 64'(illegal_cnt), 64'd0);
  endtask

  initial begin
    logic [31:0] held_data;
    rst_n     = 1'b1;
    start     = 1'b0;
    cfg_len   = '0;
    res_ready = 1'b1;
    opc256    = 9'h1FF;
    last_idx  = '0;
    clear_mem();

    // Reset state
    #2 rst_n = 1'b0;
    #2 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: add/sub with carry, borrow and zero
    mem_a[0] = 32'd1; mem_a[1] = 32'd2; mem_a[2] = 32'd3; mem_a[3] = 32'hFFFF_FFFF;
    mem_b[0] = 32'd1; mem_b[1] = 32'd1; mem_b[2] = 32'd5; mem_b[3] = 32'd1;
    mem_c[0] = 8'd0;  mem_c[1] = 8'd1;  mem_c[2] = 8'd1;  mem_c[3] = 8'd0;
    push(32'd2, 0, 3'b000);
    push(32'd1, 1, 3'b000);
    push(32'hFFFF_FFFE, 2, 3'b010);
    push(32'd0, 3, 3'b011);
    start_pass(4);
    @(negedge clk);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_valid_c0", 64'(res_valid), 64'd0);
    @(negedge clk);
    check("t1_valid_c1", 64'(res_valid), 64'd0);
    @(negedge clk);
    check("t1_valid_c2", 64'(res_valid), 64'd1);
    wait_done("t1_done", 100);
    check("t1_busy_end", 64'(busy), 64'd0);
    check("t1_last_idx", 64'(last_idx), 64'd3);
    check("t1_illegal_cnt", 64'(illegal_cnt), 64'd0);
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

    // 2: logic/mul/shift/max opcodes
    clear_mem();
    for (int i = 0; i < 7; i++) begin
      mem_a[i] = 32'hF0F0_0003;
      mem_b[i] = 32'h0000_0004;
      mem_c[i] = 8'(i + 2);
    end
    push(32'h0000_0000, 0, 3'b001);
    push(32'hF0F0_0007, 1, 3'b000);
    push(32'hF0F0_0007, 2, 3'b000);
    push(32'hC3C0_000C, 3, 3'b000);
    push(32'h0F00_0030, 4, 3'b000);
    push(32'h0F0F_0000, 5, 3'b000);
    push(32'hF0F0_0003, 6, 3'b000);
    start_pass(7);
    wait_done("t2_done", 200);
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // 3: backpressure on idx 2
    clear_mem();
    mem_a[0] = 32'd10; mem_a[1] = 32'd20; mem_a[2] = 32'd30; mem_a[3] = 32'd40;
    for (int i = 0; i < 4; i++) mem_b[i] = 32'd3;
    mem_c[0] = 8'd0; mem_c[1] = 8'd1; mem_c[2] = 8'd5; mem_c[3] = 8'd8;
    push(32'd13, 0, 3'b000);
    push(32'd17, 1, 3'b000);
    push(32'd90, 2, 3'b000);
    push(32'd40, 3, 3'b000);
    start_pass(4);
    wait_valid_idx("t3_wait_idx1", 1, 50);
    @(posedge clk);
    #1 res_ready = 1'b0;
    wait_valid_idx("t3_wait_idx2", 2, 50);
    held_data = res_data;
    check("t3_held_value", 64'(held_data), 64'd90);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t3_stall_valid", 64'(res_valid), 64'd1);
      check("t3_stall_data", 64'(res_data), 64'(held_data));
      check("t3_stall_idx", 64'(res_idx), 64'd2);
      check("t3_stall_addr", 64'(mem_addr), 64'd2);
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t3_addr_before_issue", 64'(mem_addr), 64'd2);
    @(negedge clk);
    check("t3_next_issue_addr", 64'(mem_addr), 64'd3);
    wait_done("t3_done", 100);
    check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // 4: long pass with opcode address wrap
    clear_mem();
    for (int i = 0; i < 300; i++) begin
      mem_a[i] = 32'(i);
      mem_b[i] = 32'd1;
    end
    for (int i = 0; i < 10; i++) mem_c[i] = 8'd9;
    for (int i = 0; i < 300; i++) begin
      if ((i % 256) < 10) push(32'(i), i, {1'b1, 1'b0, (i == 0)});
      else push(32'(i + 1), i, 3'b000);
    end
    start_pass(300);
    wait_done("t4_done", 3000);
    check("t4_illegal_cnt", 64'(illegal_cnt), 64'd20);
    check("t4_last_idx", 64'(last_idx), 64'd299);
    check("t4_opc_addr_256", 64'(opc256), 64'd0);
    check("t4_queue_empty", 64'(exp_q.size()), 64'd0);

    // 5: zero-length pass, then start while busy
    start_pass(0);
    @(negedge clk);
    check("t5_busy_pulse", 64'(busy), 64'd1);
    check("t5_done_low", 64'(done), 64'd0);
    check("t5_valid_c0", 64'(res_valid), 64'd0);
    @(negedge clk);
    check("t5_busy_end", 64'(busy), 64'd0);
    check("t5_done", 64'(done), 64'd1);
    check("t5_valid_c1", 64'(res_valid), 64'd0);

    clear_mem();
    mem_a[0] = 32'd7; mem_a[1] = 32'd9;
    mem_b[0] = 32'd2; mem_b[1] = 32'd4;
    mem_c[0] = 8'd1;  mem_c[1] = 8'd3;
    push(32'd5, 0, 3'b000);
    push(32'd13, 1, 3'b000);
    res_ready = 1'b0;
    start_pass(2);
    wait_valid_idx("t5_wait_idx0", 0, 20);
    start_pass(5);
    @(negedge clk);
    check("t5_ignored_idx", 64'(res_idx), 64'd0);
    check("t5_ignored_busy", 64'(busy), 64'd1);
    check("t5_ignored_done", 64'(done), 64'd0);
    @(posedge clk);
    #1 res_ready = 1'b1;
    wait_done("t5_done2", 100);
    repeat (10) @(negedge clk);
    check("t5_last_idx", 64'(last_idx), 64'd1);
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t5_idle_busy", 64'(busy), 64'd0);

    // 6: reset in the middle of a pass
    clear_mem();
    for (int i = 0; i < 10; i++) mem_a[i] = 32'(i + 100);
    for (int i = 0; i < 10; i++) mem_b[i] = 32'(i);
    for (int i = 0; i < 10; i++) push(32'(2 * i + 100), i, 3'b000);
    start_pass(10);
    wait_valid_idx("t6_wait_idx6", 6, 100);
    @(posedge clk);
    #1 res_ready = 1'b0;
    wait_valid_idx("t6_wait_idx7", 7, 50);
    rst_n = 1'b0;
    #1 check_all_zero("t6_reset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    push(32'd100, 0, 3'b000);
    push(32'd102, 1, 3'b000);
    start_pass(2);
    wait_done("t6_done", 100);
    check("t6_last_idx", 64'(last_idx), 64'd1);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
